// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the data-memory access controller and the load
// extractor downstream of it: access-size codes, load-type codes, FSM states.
package mem_access_ctrl_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;  // 2'b11 is reserved and handled as a word

  localparam logic [2:0] LOAD_TYPE_LB  = 3'd0;
  localparam logic [2:0] LOAD_TYPE_LBU = 3'd1;
  localparam logic [2:0] LOAD_TYPE_LH  = 3'd2;
  localparam logic [2:0] LOAD_TYPE_LHU = 3'd3;
  localparam logic [2:0] LOAD_TYPE_LW  = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  // A store is misaligned when its byte offset is not a multiple of its size.
  function automatic logic store_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic mis;
    case (size)
      SIZE_B:  mis = 1'b0;
      SIZE_H:  mis = off[0];
      default: mis = (off != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_store_lane_gen.sv
// Store lane generator: byte enables and lane-replicated write data for an
// aligned store, derived from the access size and the address byte offset.
module store_lane_gen
  import mem_access_ctrl_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] data_i,
  output logic [3:0]  be_o,
  output logic [31:0] data_o
);

  // Replicate the right-justified data into every lane so the enabled lanes
  // always carry the correct bytes regardless of offset.
  always_comb begin
    be_o   = 4'b1111;
    data_o = data_i;
    case (size_i)
      SIZE_B: begin
        be_o   = 4'b0001 << offset_i;
        data_o = {4{data_i[7:0]}};
      end
      SIZE_H: begin
        be_o   = offset_i[1] ? 4'b1100 : 4'b0011;
        data_o = {2{data_i[15:0]}};
      end
      default: begin
        be_o   = 4'b1111;
        data_o = data_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Data-memory access controller: accepts one load/store at a time from
// EX/MEM, runs a word-aligned bus access with wait states and timeout, and
// hands the raw load word, byte offset and load type to the extractor.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iReq,
  input  logic        iWrite,
  input  logic [31:0] iAddr,
  input  logic [31:0] iWData,
  input  logic [1:0]  iSize,
  input  logic [2:0]  iLoadType,
  output logic        oBusy,
  output logic        oMemReq,
  output logic        oMemWe,
  output logic [31:0] oMemAddr,
  output logic [3:0]  oMemBE,
  output logic [31:0] oMemWData,
  input  logic        iMemAck,
  input  logic [31:0] iMemRData,
  output logic [31:0] oRawData,
  output logic [1:0]  oAlignment,
  output logic [2:0]  oLoadTypeOut,
  output logic        oDone,
  output logic        oStoreExc,
  output logic        oBusErr
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               exc_q, exc_d;
  logic               berr_q, berr_d;
  logic               accept;
  logic               capture;

  logic               write_q;
  logic [31:0]        addr_q;
  logic [31:0]        wdata_q;
  logic [1:0]         size_q;
  logic [2:0]         ltype_q;

  logic [31:0]        rdata_q;
  logic [1:0]         align_q;
  logic [2:0]         ltout_q;

  logic [3:0]         lane_be;
  logic [31:0]        lane_data;
  logic               in_access;

  store_lane_gen u_lane (
    .size_i   (size_q),
    .offset_i (addr_q[1:0]),
    .data_i   (wdata_q),
    .be_o     (lane_be),
    .data_o   (lane_data)
  );

  // Next-state logic: accept/reject in IDLE, wait for ack or timeout in ACCESS.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    exc_d   = 1'b0;
    berr_d  = 1'b0;
    accept  = 1'b0;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (iReq) begin
          if (iWrite && store_misaligned(iSize, iAddr[1:0])) begin
            exc_d = 1'b1;
          end else begin
            accept  = 1'b1;
            cnt_d   = '0;
            state_d = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        if (iMemAck) begin
          capture = !write_q;
          state_d = ST_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          berr_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control state: FSM, wait counter and the one-cycle exception pulses.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      exc_q   <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      exc_q   <= exc_d;
      berr_q  <= berr_d;
    end
  end

  // Latch the accepted request; bus outputs are gated outside ACCESS so these
  // registers need no reset.
  always_ff @(posedge iCLK) begin
    if (accept) begin
      write_q <= iWrite;
      addr_q  <= iAddr;
      wdata_q <= iWData;
      size_q  <= iSize;
      ltype_q <= iLoadType;
    end
  end

  // Load result registers: updated only when a load is acknowledged, held
  // through stores, exceptions and timeouts.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      rdata_q <= '0;
      align_q <= '0;
      ltout_q <= '0;
    end else if (capture) begin
      rdata_q <= iMemRData;
      align_q <= addr_q[1:0];
      ltout_q <= ltype_q;
    end
  end

  assign in_access    = (state_q == ST_ACCESS);
  assign oBusy        = in_access;
  assign oMemReq      = in_access;
  assign oMemWe       = in_access && write_q;
  assign oMemAddr     = in_access ? {addr_q[31:2], 2'b00} : 32'h0;
  assign oMemBE       = in_access ? (write_q ? lane_be : 4'b1111) : 4'b0000;
  assign oMemWData    = (in_access && write_q) ? lane_data : 32'h0;
  assign oDone        = (state_q == ST_RESP);
  assign oStoreExc    = exc_q;
  assign oBusErr      = berr_q;
  assign oRawData     = rdata_q;
  assign oAlignment   = align_q;
  assign oLoadTypeOut = ltout_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed scenarios followed by
// randomized load/store traffic against a transaction-level reference model.
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  localparam int TIMEOUT = 16;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic        iReq;
  logic        iWrite;
  logic [31:0] iAddr;
  logic [31:0] iWData;
  logic [1:0]  iSize;
  logic [2:0]  iLoadType;
  logic        oBusy;
  logic        oMemReq;
  logic        oMemWe;
  logic [31:0] oMemAddr;
  logic [3:0]  oMemBE;
  logic [31:0] oMemWData;
  logic        iMemAck;
  logic [31:0] iMemRData;
  logic [31:0] oRawData;
  logic [1:0]  oAlignment;
  logic [2:0]  oLoadTypeOut;
  logic        oDone;
  logic        oStoreExc;
  logic        oBusErr;

  mem_access_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .iCLK(iCLK), .iRST(iRST), .iReq(iReq), .iWrite(iWrite), .iAddr(iAddr),
    .iWData(iWData), .iSize(iSize), .iLoadType(iLoadType), .oBusy(oBusy),
    .oMemReq(oMemReq), .oMemWe(oMemWe), .oMemAddr(oMemAddr), .oMemBE(oMemBE),
    .oMemWData(oMemWData), .iMemAck(iMemAck), .iMemRData(iMemRData),
    .oRawData(oRawData), .oAlignment(oAlignment), .oLoadTypeOut(oLoadTypeOut),
    .oDone(oDone), .oStoreExc(oStoreExc), .oBusErr(oBusErr)
  );

  always #5 iCLK = ~iCLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: the last completed load as the extractor sees it.
  logic [31:0] m_raw;
  logic [1:0]  m_align;
  logic [2:0]  m_lt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit model_misaligned(input logic wr, input logic [31:0] addr, input logic [1:0] sz);
    return wr && ((int'(addr[1:0]) % nbytes(sz)) != 0);
  endfunction

  // Bytes [off, off+n) are enabled for an aligned store; loads read all four.
  function automatic logic [3:0] model_be(input logic wr, input logic [31:0] addr, input logic [1:0] sz);
    logic [3:0] be;
    int off, n;
    if (!wr) return 4'hF;
    be = 4'h0;
    off = int'(addr[1:0]);
    n = nbytes(sz);
    for (int i = 0; i < 4; i++)
      if (i >= off && i < off + n) be[i] = 1'b1;
    return be;
  endfunction

  // Lane i carries store byte (i mod size).
  function automatic logic [31:0] model_wdata(input logic [31:0] d, input logic [1:0] sz);
    logic [31:0] r;
    int n;
    n = nbytes(sz);
    for (int i = 0; i < 4; i++)
      r[8*i +: 8] = d[8*(i % n) +: 8];
    return r;
  endfunction

  task automatic idle_cycle();
    check("idle_busy", oBusy, 1'b0);
    check("idle_req", oMemReq, 1'b0);
    check("idle_done", oDone, 1'b0);
    @(negedge iCLK);
  endtask

  // Entered and left at a negedge with the DUT in IDLE.
  task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [1:0] sz, input logic [2:0] lt, input int waits,
                         input logic [31:0] rdata);
    bit acked;
    iReq = 1'b1; iWrite = wr; iAddr = addr; iWData = data; iSize = sz; iLoadType = lt;
    @(negedge iCLK);
    iReq = 1'b0; iAddr = $urandom; iWData = $urandom; iSize = 2'($urandom); iLoadType = 3'($urandom);
    if (model_misaligned(wr, addr, sz)) begin
      check("exc_pulse", oStoreExc, 1'b1);
      check("exc_noreq", oMemReq, 1'b0);
      check("exc_busy", oBusy, 1'b0);
      check("exc_raw_hold", oRawData, m_raw);
      @(negedge iCLK);
      check("exc_once", oStoreExc, 1'b0);
      check("exc_noreq2", oMemReq, 1'b0);
      return;
    end
    acked = 1'b0;
    for (int k = 0; k < TIMEOUT; k++) begin
      check("acc_req", oMemReq, 1'b1);
      check("acc_busy", oBusy, 1'b1);
      check("acc_we", oMemWe, wr);
      check("acc_addr", oMemAddr, {addr[31:2], 2'b00});
      check("acc_be", oMemBE, model_be(wr, addr, sz));
      if (wr) check("acc_wdata", oMemWData, model_wdata(data, sz));
      check("acc_done", oDone, 1'b0);
      check("acc_berr", oBusErr, 1'b0);
      if (k == waits) begin
        iMemAck = 1'b1; iMemRData = rdata; acked = 1'b1;
      end
      @(negedge iCLK);
      iMemAck = 1'b0; iMemRData = $urandom;
      if (acked) break;
    end
    if (acked) begin
      if (!wr) begin
        m_raw = rdata; m_align = addr[1:0]; m_lt = lt;
      end
      check("resp_done", oDone, 1'b1);
      check("resp_busy", oBusy, 1'b0);
      check("resp_req", oMemReq, 1'b0);
      check("resp_raw", oRawData, m_raw);
      check("resp_align", oAlignment, m_align);
      check("resp_lt", oLoadTypeOut, m_lt);
      @(negedge iCLK);
      check("post_done", oDone, 1'b0);
      check("post_busy", oBusy, 1'b0);
    end else begin
      check("to_berr", oBusErr, 1'b1);
      check("to_req", oMemReq, 1'b0);
      check("to_busy", oBusy, 1'b0);
      check("to_done", oDone, 1'b0);
      check("to_raw_hold", oRawData, m_raw);
    end
  endtask

  initial begin
    int r, w;
    logic [1:0] sz;
    iRST = 1'b1; iReq = 1'b0; iWrite = 1'b0; iAddr = '0; iWData = '0; iSize = '0;
    iLoadType = '0; iMemAck = 1'b0; iMemRData = '0;
    m_raw = '0; m_align = '0; m_lt = '0;
    repeat (2) @(negedge iCLK);
    check("rst_busy", oBusy, 1'b0);
    check("rst_req", oMemReq, 1'b0);
    check("rst_be", oMemBE, 4'h0);
    check("rst_raw", oRawData, 32'h0);
    check("rst_align", oAlignment, 2'b00);
    check("rst_lt", oLoadTypeOut, 3'd0);
    check("rst_pulses", {oDone, oStoreExc, oBusErr}, 3'b000);
    iRST = 1'b0;
    @(negedge iCLK);

    // Word load, immediate ack.
    run_txn(1'b0, 32'h0000_1004, 32'h0, SIZE_W, LOAD_TYPE_LW, 0, 32'hDEAD_BEEF);
    // Byte store at the top lane after three wait states.
    run_txn(1'b1, 32'h0000_2003, 32'h1234_56A5, SIZE_B, 3'd0, 3, 32'h0);
    // Misaligned half store: exception only.
    run_txn(1'b1, 32'h0000_3001, 32'h0000_BEEF, SIZE_H, 3'd0, 0, 32'h0);
    // Timeout, then a request accepted in the very next cycle.
    run_txn(1'b0, 32'h0000_4000, 32'h0, SIZE_W, LOAD_TYPE_LW, TIMEOUT + 5, 32'h0);
    run_txn(1'b0, 32'h0000_4006, 32'h0, SIZE_H, LOAD_TYPE_LHU, 1, 32'h0BAD_F00D);
    // Ack on the last permitted cycle still completes.
    run_txn(1'b1, 32'h0000_4008, 32'hCAFE_0001, SIZE_W, 3'd0, TIMEOUT - 1, 32'h0);

    // Reset during a pending load; a late ack must be ignored.
    iReq = 1'b1; iWrite = 1'b0; iAddr = 32'h0000_5008; iSize = SIZE_W; iLoadType = LOAD_TYPE_LW;
    @(negedge iCLK);
    iReq = 1'b0;
    check("rstmid_req_before", oMemReq, 1'b1);
    @(negedge iCLK);
    iRST = 1'b1;
    @(negedge iCLK);
    iRST = 1'b0;
    m_raw = '0; m_align = '0; m_lt = '0;
    check("rstmid_req", oMemReq, 1'b0);
    check("rstmid_busy", oBusy, 1'b0);
    check("rstmid_raw", oRawData, 32'h0);
    check("rstmid_lt", oLoadTypeOut, 3'd0);
    iMemAck = 1'b1; iMemRData = 32'h7777_7777;
    @(negedge iCLK);
    iMemAck = 1'b0;
    check("late_ack_done", oDone, 1'b0);
    check("late_ack_req", oMemReq, 1'b0);
    check("late_ack_raw", oRawData, 32'h0);

    // Back-to-back halfword load then word store.
    run_txn(1'b0, 32'h0000_0010, 32'h0, SIZE_H, LOAD_TYPE_LH, 0, 32'h1357_9BDF);
    run_txn(1'b1, 32'h0000_0020, 32'hA1B2_C3D4, SIZE_W, 3'd0, 0, 32'h0);

    // Randomized traffic.
    for (int t = 0; t < 200; t++) begin
      r = $urandom_range(0, 9);
      w = (r < 7) ? r : (r == 7) ? TIMEOUT - 1 : TIMEOUT + 3;
      sz = 2'($urandom_range(0, 3));
      run_txn(1'($urandom_range(0, 1)), $urandom, $urandom, sz, 3'($urandom_range(0, 7)), w, $urandom);
      for (int g = $urandom_range(0, 2); g > 0; g--) idle_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Data-memory access controller between the EX/MEM stage and the data-memory bus, directly upstream of the load extractor (sign/zero extension stage). It accepts one load/store request at a time and issues a word-aligned bus access with byte enables, waiting out variable-latency wait states. Store data is lane-replicated. For loads it delivers the raw 32-bit word, the address byte offset and the load type to the extractor. It stalls the pipeline while an access is in flight and flags misaligned stores and bus timeouts.

Parameters:
TIMEOUT, 16, max cycles oMemReq may wait for iMemAck before a bus error (>=2)
CNT_W, $clog2(TIMEOUT+1), width of the wait counter

Ports:
iCLK  in  1  clock, all state on rising edge
iRST  in  1  synchronous active-high reset
iReq  in  1  request valid from EX/MEM; sampled only when oBusy=0
iWrite  in  1  1=store, 0=load
iAddr  in  32  byte address
iWData  in  32  store data, right-justified
iSize  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
iLoadType  in  3  load-type code, forwarded unchanged for loads
oBusy  out  1  pipeline stall; high from the cycle after accept until the cycle of oDone
oMemReq  out  1  bus request, held until ack
oMemWe  out  1  bus write enable
oMemAddr  out  32  {iAddr[31:2],2'b00}
oMemBE  out  4  byte enables
oMemWData  out  32  lane-replicated store data
iMemAck  in  1  bus acknowledge; read data valid in the same cycle
iMemRData  in  32  bus read data
oRawData  out  32  registered read word to the extractor
oAlignment  out  2  registered iAddr[1:0] of the completed load
oLoadTypeOut  out  3  registered load type of the completed load
oDone  out  1  one-cycle pulse: access finished (load data valid on the outputs or store committed)
oStoreExc  out  1  one-cycle pulse: misaligned store, no bus access
oBusErr  out  1  one-cycle pulse: timeout, access abandoned

Behaviour:
- Reset: state=IDLE. All outputs 0, including the registered oRawData, oAlignment, oLoadTypeOut, and the counter. Reset mid-access drops oMemReq the next cycle; a late iMemAck after reset is ignored.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - iReq=1 with iWrite=1 and a misaligned store (half with addr[0]=1; word with addr[1:0]!=0): pulse oStoreExc next cycle. No bus access; stay IDLE.
  - Any other request: latch the request into registers and go to ACCESS.
- ACCESS:
  - oMemReq=1 and address/BE/data are stable from the latched request; counter counts cycles spent in ACCESS.
  - iMemAck=1: capture iMemRData (loads) and go to RESP.
  - Counter reaches TIMEOUT-1 with no ack: go to IDLE and pulse oBusErr in the same cycle the state becomes IDLE.
- RESP:
  - oDone=1 for one cycle; oBusy=0 in this cycle so EX/MEM advances; go to IDLE.
  - Load outputs update at the RESP entry edge and hold until the next load completes; stores leave them unchanged.
- Latency: accept at edge N; oMemReq high in cycle N+1. With ack in cycle N+1, oDone is in cycle N+2. Each wait state adds one cycle.
- A new iReq is accepted only in IDLE, so back-to-back throughput is one access per 3 cycles minimum.
- Byte enables:
  - Byte: 1<<addr[1:0].
  - Half: addr[1]?1100:0011.
  - Word: 1111.
  - Loads drive BE=1111 and oMemWe=0.
- Store data replication:
  - Byte: {4{d[7:0]}}.
  - Half: {2{d[15:0]}}.
  - Word: d.
- Misaligned loads are issued normally; the extractor raises their exception from oAlignment.
- When not in ACCESS: oMemReq=0, oMemWe=0, oMemBE=0.

Decomposition:
- Shared package: SIZE_B/H/W codes, LOAD_TYPE_* codes (shared with the extractor), state encoding.
- One sub-module, store_lane_gen: combinational BE + replicated data from size/offset. Reusable by the store path of the other cores.

Test Plan:
- Load word, addr 0x1004, ack in the first ACCESS cycle, RData 0xDEADBEEF -> oMemAddr 0x1004, BE 1111, oDone at N+2, oRawData 0xDEADBEEF, oAlignment 00.
- Store byte 0xA5 to 0x2003, ack after 3 waits -> BE 1000, WData 0xA5A5A5A5, We=1, oBusy high 4 cycles, oDone at N+5.
- Store half to 0x3001 -> oStoreExc pulse next cycle, oMemReq never asserted, oBusy stays 0.
- Load with no ack, TIMEOUT=16 -> oMemReq high 16 cycles, then oBusErr pulse, state IDLE, a new request accepted next cycle.
- iRST during ACCESS (load pending), then ack asserted -> oMemReq 0 the cycle after reset, no oDone, outputs 0.
- Back-to-back load halfword 0x10 (ack immediate) then store word 0x20 -> second accept exactly at RESP+1, oLoadTypeOut/oAlignment hold the load values through the store.
